// File: rtl/rrat_recovery_ctrl_if.sv
// Recovery-control bus: groups the flush request, retired-RAT snapshot,
// free-list backpressure and every strobe the recovery sequencer drives.
//   master : the recovery controller (drives stalls, RAT writes, free-list ops)
//   slave  : the surrounding pipeline (ROB, RATs, free list)
interface rrat_recovery_ctrl_if #(
   parameter int NUM_PREGS  = 64,
   parameter int COPY_WIDTH = 4
);
   localparam int IW = $clog2(NUM_PREGS);

   logic                            flush_req;
   logic [31:0][IW-1:0]             arc_reg_in;
   logic                            fl_full;
   logic                            commit_stall;
   logic                            dispatch_stall;
   logic                            rat_wr_en;
   logic [4:0]                      rat_wr_base;
   logic [COPY_WIDTH-1:0][IW-1:0]   rat_wr_data;
   logic                            fl_clear;
   logic                            fl_enq;
   logic [IW-1:0]                   fl_enq_idx;
   logic                            busy;
   logic                            done;

   modport master (
      input  flush_req, arc_reg_in, fl_full,
      output commit_stall, dispatch_stall, rat_wr_en, rat_wr_base, rat_wr_data,
             fl_clear, fl_enq, fl_enq_idx, busy, done
   );

   modport slave (
      output flush_req, arc_reg_in, fl_full,
      input  commit_stall, dispatch_stall, rat_wr_en, rat_wr_base, rat_wr_data,
             fl_clear, fl_enq, fl_enq_idx, busy, done
   );
endinterface

// File: rtl/rrat_recovery_ctrl.sv
// Retired-RAT recovery sequencer. After a flush it freezes commit, copies the
// 32 retired mappings into the front-end RAT COPY_WIDTH entries per cycle, then
// walks every physical register and enqueues those the retired RAT does not
// reference into the (freshly cleared) free list.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : rrat_recovery_ctrl_if.master (flush_req/arc_reg_in/fl_full in;
//              stalls, RAT group write, free-list clear/enqueue, busy/done out)
module rrat_recovery_ctrl #(
   parameter int NUM_PREGS  = 64,
   parameter int COPY_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   rrat_recovery_ctrl_if.master  bus
);
   localparam int         IW        = $clog2(NUM_PREGS);
   localparam logic [4:0] LAST_BASE = 5'(32 - COPY_WIDTH);

   typedef enum logic [2:0] {IDLE, CLEAR, COPY, SCAN, DONE} state_t;

   state_t               state, state_nxt;
   logic [4:0]           copy_cnt, copy_cnt_nxt;
   logic [IW-1:0]        scan_p, scan_p_nxt;
   logic [NUM_PREGS-1:0] used, used_nxt, used_map;
   logic                 scan_adv;

   // Bitmap of physical registers referenced by the retired RAT. p0 is the
   // hard-wired zero register and is never handed out.
   always_comb begin
      used_map = '0;
      for (int i = 0; i < 32; i++) used_map[bus.arc_reg_in[i]] = 1'b1;
      used_map[0] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         copy_cnt <= '0;
         scan_p   <= '0;
         used     <= '0;
      end else begin
         state    <= state_nxt;
         copy_cnt <= copy_cnt_nxt;
         scan_p   <= scan_p_nxt;
         used     <= used_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      copy_cnt_nxt = copy_cnt;
      scan_p_nxt   = scan_p;
      used_nxt     = used;
      // A used index never waits; an unused one waits for free-list space.
      scan_adv     = used[scan_p] | ~bus.fl_full;
      case (state)
         IDLE:  if (bus.flush_req) state_nxt = CLEAR;
         CLEAR: begin
            used_nxt     = used_map;
            copy_cnt_nxt = '0;
            scan_p_nxt   = '0;
            state_nxt    = COPY;
         end
         COPY: begin
            copy_cnt_nxt = copy_cnt + 5'(COPY_WIDTH);
            if (copy_cnt == LAST_BASE) state_nxt = SCAN;
         end
         SCAN: begin
            if (scan_adv) begin
               scan_p_nxt = scan_p + IW'(1);
               if (scan_p == IW'(NUM_PREGS - 1)) state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.busy           = (state != IDLE);
   // The flush cycle itself must already block commit; reset masks the request.
   assign bus.commit_stall   = bus.busy | (bus.flush_req & ~rst);
   assign bus.dispatch_stall = bus.commit_stall;
   assign bus.fl_clear       = (state == CLEAR);
   assign bus.rat_wr_en      = (state == COPY);
   assign bus.rat_wr_base    = bus.rat_wr_en ? copy_cnt : '0;
   assign bus.fl_enq         = (state == SCAN) & ~used[scan_p] & ~bus.fl_full;
   assign bus.fl_enq_idx     = bus.fl_enq ? scan_p : '0;
   assign bus.done           = (state == DONE);

   for (genvar k = 0; k < COPY_WIDTH; k++) begin : g_lane
      assign bus.rat_wr_data[k] = bus.rat_wr_en ? bus.arc_reg_in[5'(copy_cnt + 5'(k))] : '0;
   end
endmodule

// File: tb/tb_rrat_recovery_ctrl.sv
// Scoreboard bench for rrat_recovery_ctrl. Stimulus computes each recovery's
// expected RAT writes, enqueue list and done cycle from the mapping and the
// planned fl_full pattern; a negedge monitor pops and compares. A second
// COPY_WIDTH=1 instance runs in parallel with fl_full tied low.
module tb_rrat_recovery_ctrl;
   localparam int NP = 64;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rrat_recovery_ctrl_if #(.NUM_PREGS(NP), .COPY_WIDTH(CW)) bus ();
   rrat_recovery_ctrl_if #(.NUM_PREGS(NP), .COPY_WIDTH(1))  bus1 ();

   assign bus1.flush_req  = bus.flush_req;
   assign bus1.arc_reg_in = bus.arc_reg_in;
   assign bus1.fl_full    = 1'b0;

   rrat_recovery_ctrl #(.NUM_PREGS(NP), .COPY_WIDTH(CW)) dut  (.clk(clk), .rst(rst), .bus(bus.master));
   rrat_recovery_ctrl #(.NUM_PREGS(NP), .COPY_WIDTH(1))  dut1 (.clk(clk), .rst(rst), .bus(bus1.master));

   typedef struct packed {
      logic [4:0]             base;
      logic [CW-1:0][5:0]     data;
   } wr_t;

   wr_t              exp_wr[$];
   logic [5:0]       exp_enq[$];
   int               exp_clr[$];
   int               exp_done[$];
   int               exp_done1[$];
   int               stall_lo = -1;
   int               stall_hi = -2;
   logic [31:0][5:0] cur_arc;
   bit               full_pat [0:255];
   int               w1 = 0;
   int               errors = 0;
   int               checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares every observable output once per cycle.
   always @(negedge clk) begin
      if (rst) begin
         w1 = 0;
         chk("rst_outputs",
             {bus.commit_stall, bus.dispatch_stall, bus.rat_wr_en, bus.fl_clear, bus.fl_enq,
              bus.busy, bus.done, |bus.rat_wr_base, |bus.rat_wr_data, |bus.fl_enq_idx,
              bus1.commit_stall, bus1.rat_wr_en, bus1.fl_clear, bus1.fl_enq, bus1.busy, bus1.done},
             '0);
      end else begin
         chk("commit_stall",   bus.commit_stall,   (cyc >= stall_lo) && (cyc <= stall_hi));
         chk("dispatch_stall", bus.dispatch_stall, (cyc >= stall_lo) && (cyc <= stall_hi));
         chk("busy",           bus.busy,           (cyc >  stall_lo) && (cyc <= stall_hi));
         if (bus.fl_clear) begin
            if (exp_clr.size() == 0) chk("fl_clear_unexpected", bus.fl_clear, 0);
            else                     chk("fl_clear_cycle", cyc, exp_clr.pop_front());
         end
         if (bus.rat_wr_en) begin
            if (exp_wr.size() == 0) chk("rat_wr_unexpected", bus.rat_wr_en, 0);
            else                    chk("rat_wr", {bus.rat_wr_base, bus.rat_wr_data}, exp_wr.pop_front());
         end else begin
            chk("rat_wr_data_idle", bus.rat_wr_data, 0);
         end
         if (bus.fl_enq) begin
            chk("enq_while_full", bus.fl_full, 0);
            if (exp_enq.size() == 0) chk("enq_unexpected", bus.fl_enq, 0);
            else                     chk("enq_idx", bus.fl_enq_idx, exp_enq.pop_front());
         end else begin
            chk("enq_idx_idle", bus.fl_enq_idx, 0);
         end
         if (bus.done) begin
            if (exp_done.size() == 0) chk("done_unexpected", bus.done, 0);
            else                      chk("done_cycle", cyc, exp_done.pop_front());
         end
         if (bus1.rat_wr_en) begin
            chk("w1_base", bus1.rat_wr_base, w1);
            chk("w1_data", bus1.rat_wr_data, cur_arc[w1]);
            w1++;
         end
         if (bus1.done) begin
            if (exp_done1.size() == 0) chk("done1_unexpected", bus1.done, 0);
            else begin
               chk("done1_cycle", cyc, exp_done1.pop_front());
               chk("w1_count", w1, 32);
            end
            w1 = 0;
         end
      end
   end

   // One recovery. dup_at>0 re-pulses flush_req dup_at cycles after the first;
   // rst_at>0 asserts reset when the scan reaches physical index rst_at.
   task automatic run(input logic [31:0][5:0] arc, input int dup_at, input int rst_at);
      int F, S, D, t, lim;
      bit used [NP];
      @(posedge clk); #1;
      bus.arc_reg_in = arc;
      cur_arc        = arc;
      bus.flush_req  = 1'b1;
      F = cyc;
      for (int p = 0; p < NP; p++) used[p] = 1'b0;
      used[0] = 1'b1;
      for (int i = 0; i < 32; i++) used[arc[i]] = 1'b1;
      exp_clr.push_back(F + 1);
      for (int b = 0; b < 32; b += CW) begin
         wr_t w;
         w.base = 5'(b);
         for (int k = 0; k < CW; k++) w.data[k] = arc[b + k];
         exp_wr.push_back(w);
      end
      for (int p = 0; p < NP; p++) if (!used[p]) exp_enq.push_back(6'(p));
      // Scan begins after CLEAR and the copy groups; each free index waits out
      // any fl_full cycles it meets, every index then takes one cycle.
      S = F + 2 + 32 / CW;
      t = 0;
      for (int p = 0; p < NP; p++) begin
         if (!used[p]) while (full_pat[t]) t++;
         t++;
      end
      D = S + t;
      exp_done.push_back(D);
      exp_done1.push_back(F + 2 + 32 + NP);
      stall_lo = F;
      stall_hi = D;
      lim = ((D > F + 2 + 32 + NP) ? D : F + 2 + 32 + NP) + 3;
      @(posedge clk); #1;
      bus.flush_req = 1'b0;
      while (cyc < lim) begin
         bus.fl_full   = (cyc >= S) ? full_pat[cyc - S] : 1'($urandom_range(0, 1));
         bus.flush_req = (dup_at > 0) && (cyc == F + dup_at);
         if (rst_at > 0 && cyc == S + rst_at) begin
            rst = 1'b1;
            exp_wr.delete(); exp_enq.delete(); exp_clr.delete();
            exp_done.delete(); exp_done1.delete();
            stall_lo = -1;
            stall_hi = -2;
            bus.flush_req = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            rst = 1'b0;
            bus.flush_req = 1'b0;
            break;
         end
         @(posedge clk); #1;
      end
      bus.fl_full   = 1'b0;
      bus.flush_req = 1'b0;
   endtask

   initial begin
      logic [31:0][5:0] id, rev, rnd;
      for (int i = 0; i < 32; i++) begin
         id[i]  = 6'(i);
         rev[i] = 6'(63 - i);
      end
      rev[0] = 6'd0;
      for (int t = 0; t < 256; t++) full_pat[t] = 1'b0;
      bus.flush_req  = 1'b1;
      bus.fl_full    = 1'b0;
      bus.arc_reg_in = '0;
      cur_arc        = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      bus.flush_req = 1'b0;
      repeat (2) @(posedge clk);

      run(id, 0, 0);
      run(rev, 0, 0);
      for (int t = 40; t < 45; t++) full_pat[t] = 1'b1;
      run(id, 0, 0);
      for (int t = 0; t < 256; t++) full_pat[t] = 1'b0;
      run(id, 10, 0);
      run(id, 0, 45);
      run(id, 0, 0);

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 32; i++) rnd[i] = 6'($urandom_range(0, 63));
         for (int t = 0; t < 256; t++) full_pat[t] = (t < 120) && ($urandom_range(0, 3) == 0);
         run(rnd, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 70)) : 0, 0);
      end

      repeat (3) @(posedge clk);
      chk("leftover_wr",    exp_wr.size(),    0);
      chk("leftover_enq",   exp_enq.size(),   0);
      chk("leftover_done",  exp_done.size(),  0);
      chk("leftover_done1", exp_done1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
